// File: rtl/zap_fetch_fifo.sv
// Fetch-to-decode instruction buffer: DEPTH-entry FWFT FIFO, 1-cycle push-to-head latency.
// Backpressure: o_full holds fetch; pushes while full or abort-locked are dropped; i_stall holds the head.
module zap_fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_clear,
  input  logic                       i_stall,
  input  logic                       i_valid,
  input  logic [31:0]                i_instruction,
  input  logic                       i_instr_abort,
  input  logic [31:0]                i_pc_ff,
  input  logic [31:0]                i_pc_plus_8_ff,
  input  logic [1:0]                 i_taken,
  output logic                       o_full,
  output logic                       o_valid,
  output logic [31:0]                o_instruction,
  output logic                       o_instr_abort,
  output logic [31:0]                o_pc_ff,
  output logic [31:0]                o_pc_plus_8_ff,
  output logic [1:0]                 o_taken,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 99;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          abort_lock_ff;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign o_valid = (count != '0);
  assign o_full  = (count == CW'(DEPTH));
  assign o_count = count;

  assign push = i_valid & ~o_full & ~abort_lock_ff & ~i_clear;
  assign pop  = o_valid & ~i_stall & ~i_clear;

  // Storage is deliberately unreset; payload outputs are gated by o_valid instead.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_taken, i_pc_plus_8_ff, i_pc_ff, i_instr_abort, i_instruction};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      abort_lock_ff <= 1'b0;
    end else if (i_clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      abort_lock_ff <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // An aborted fetch freezes intake until the pipeline is flushed.
      if (push && i_instr_abort) begin
        abort_lock_ff <= 1'b1;
      end
    end
  end

  assign head           = o_valid ? mem[rd_ptr] : '0;
  assign o_instruction  = head[31:0];
  assign o_instr_abort  = head[32];
  assign o_pc_ff        = head[64:33];
  assign o_pc_plus_8_ff = head[96:65];
  assign o_taken        = head[98:97];

endmodule

// File: tb/tb_zap_fetch_fifo.sv
// Bench for zap_fetch_fifo: vector table, directed corner sequences, and random traffic
// against a queue-based reference model.
module tb_zap_fetch_fifo;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_clear;
  logic        i_stall;
  logic        i_valid;
  logic [31:0] i_instruction;
  logic        i_instr_abort;
  logic [31:0] i_pc_ff;
  logic [31:0] i_pc_plus_8_ff;
  logic [1:0]  i_taken;
  logic        o_full;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic        o_instr_abort;
  logic [31:0] o_pc_ff;
  logic [31:0] o_pc_plus_8_ff;
  logic [1:0]  o_taken;
  logic [2:0]  o_count;

  zap_fetch_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_clear        (i_clear),
    .i_stall        (i_stall),
    .i_valid        (i_valid),
    .i_instruction  (i_instruction),
    .i_instr_abort  (i_instr_abort),
    .i_pc_ff        (i_pc_ff),
    .i_pc_plus_8_ff (i_pc_plus_8_ff),
    .i_taken        (i_taken),
    .o_full         (o_full),
    .o_valid        (o_valid),
    .o_instruction  (o_instruction),
    .o_instr_abort  (o_instr_abort),
    .o_pc_ff        (o_pc_ff),
    .o_pc_plus_8_ff (o_pc_plus_8_ff),
    .o_taken        (o_taken),
    .o_count        (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] ins;
    logic        ab;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [1:0]  tk;
  } ent_t;

  typedef struct {
    bit          v;
    logic [31:0] ins;
    bit          ab;
    bit          st;
    bit          cl;
    bit          ev;
    bit          ef;
    int          ec;
    logic [31:0] ei;
    bit          ea;
  } vec_t;

  ent_t mq[$];
  bit   mlock;
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t h;
    h = '{ins: 32'h0, ab: 1'b0, pc: 32'h0, pc8: 32'h0, tk: 2'b0};
    if (mq.size() != 0) h = mq[0];
    chk({tag, ".valid"}, 64'(o_valid), 64'(mq.size() != 0));
    chk({tag, ".full"},  64'(o_full),  64'(mq.size() == DEPTH));
    chk({tag, ".count"}, 64'(o_count), 64'(mq.size()));
    chk({tag, ".instr"}, 64'(o_instruction), 64'(h.ins));
    chk({tag, ".abort"}, 64'(o_instr_abort), 64'(h.ab));
    chk({tag, ".pc"},    64'(o_pc_ff),  64'(h.pc));
    chk({tag, ".pc8"},   64'(o_pc_plus_8_ff), 64'(h.pc8));
    chk({tag, ".taken"}, 64'(o_taken), 64'(h.tk));
  endtask

  // One clock: drive inputs, advance the queue model by the FIFO rules, compare after the edge.
  task automatic cycle(input bit v, input logic [31:0] ins, input bit ab, input logic [31:0] pc,
                       input logic [1:0] tk, input bit st, input bit cl, input string tag);
    bit   do_push;
    bit   do_pop;
    ent_t e;
    i_valid        = v;
    i_instruction  = ins;
    i_instr_abort  = ab;
    i_pc_ff        = pc;
    i_pc_plus_8_ff = pc + 32'd8;
    i_taken        = tk;
    i_stall        = st;
    i_clear        = cl;
    do_push = v && (mq.size() < DEPTH) && !mlock && !cl;
    do_pop  = (mq.size() != 0) && !st && !cl;
    e = '{ins: ins, ab: ab, pc: pc, pc8: pc + 32'd8, tk: tk};
    @(posedge i_clk);
    if (cl) begin
      mq.delete();
      mlock = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        if (ab) mlock = 1'b1;
      end
    end
    #1;
    check_all(tag);
  endtask

  function automatic vec_t mk(bit v, logic [31:0] ins, bit ab, bit st, bit cl,
                              bit ev, bit ef, int ec, logic [31:0] ei, bit ea);
    vec_t r;
    r = '{v: v, ins: ins, ab: ab, st: st, cl: cl, ev: ev, ef: ef, ec: ec, ei: ei, ea: ea};
    return r;
  endfunction

  initial begin
    i_reset_n = 1'b0;
    i_clear = 0; i_stall = 0; i_valid = 0; i_instruction = 0; i_instr_abort = 0;
    i_pc_ff = 0; i_pc_plus_8_ff = 0; i_taken = 0;
    mlock = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");
    #2 i_reset_n = 1'b1;

    // Back-pressure, clear priority, abort lock, clear while full.
    tbl.push_back(mk(1, 32'h31, 0, 1, 0, 1, 0, 1, 32'h31, 0));
    tbl.push_back(mk(1, 32'h32, 0, 1, 0, 1, 0, 2, 32'h31, 0));
    tbl.push_back(mk(1, 32'h33, 0, 1, 0, 1, 0, 3, 32'h31, 0));
    tbl.push_back(mk(1, 32'h34, 0, 1, 0, 1, 1, 4, 32'h31, 0));
    tbl.push_back(mk(1, 32'h35, 0, 1, 0, 1, 1, 4, 32'h31, 0));
    tbl.push_back(mk(1, 32'h36, 0, 1, 0, 1, 1, 4, 32'h31, 0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 3, 32'h32, 0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 2, 32'h33, 0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 1, 32'h34, 0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'h41, 0, 1, 0, 1, 0, 1, 32'h41, 0));
    tbl.push_back(mk(1, 32'h42, 0, 1, 0, 1, 0, 2, 32'h41, 0));
    tbl.push_back(mk(1, 32'h43, 0, 1, 0, 1, 0, 3, 32'h41, 0));
    tbl.push_back(mk(1, 32'h44, 0, 0, 1, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'hA0, 0, 1, 0, 1, 0, 1, 32'hA0, 0));
    tbl.push_back(mk(1, 32'hB0, 1, 1, 0, 1, 0, 2, 32'hA0, 0));
    tbl.push_back(mk(1, 32'hC0, 0, 1, 0, 1, 0, 2, 32'hA0, 0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1, 0, 1, 32'hB0, 1));
    tbl.push_back(mk(1, 32'hD0, 0, 0, 0, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 1, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'hD0, 0, 1, 0, 1, 0, 1, 32'hD0, 0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 32'h51, 0, 1, 0, 1, 0, 1, 32'h51, 0));
    tbl.push_back(mk(1, 32'h52, 0, 1, 0, 1, 0, 2, 32'h51, 0));
    tbl.push_back(mk(1, 32'h53, 0, 1, 0, 1, 0, 3, 32'h51, 0));
    tbl.push_back(mk(1, 32'h54, 0, 1, 0, 1, 1, 4, 32'h51, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 1, 0, 0, 0, 32'h0,  0));
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].ins, tbl[i].ab, tbl[i].ins, 2'd0, tbl[i].st, tbl[i].cl, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.valid", i), 64'(o_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d.full", i),  64'(o_full),  64'(tbl[i].ef));
      chk($sformatf("tbl%0d.count", i), 64'(o_count), 64'(tbl[i].ec));
      chk($sformatf("tbl%0d.instr", i), 64'(o_instruction), 64'(tbl[i].ei));
      chk($sformatf("tbl%0d.abort", i), 64'(o_instr_abort), 64'(tbl[i].ea));
    end

    // Asynchronous reset between edges with 3 entries queued.
    for (int k = 0; k < 3; k++) cycle(1, 32'h70 + k, 0, 32'h700, 2'd1, 1, 0, "prefill");
    #2 i_reset_n = 1'b0;
    #1;
    chk("async_rst.valid", 64'(o_valid), 64'd0);
    chk("async_rst.count", 64'(o_count), 64'd0);
    chk("async_rst.instr", 64'(o_instruction), 64'd0);
    mq.delete();
    mlock = 1'b0;
    #2 i_reset_n = 1'b1;
    cycle(1, 32'hE000_0000, 0, 32'h200, 2'd2, 1, 0, "post_rst");
    chk("post_rst.head", 64'(o_instruction), 64'hE000_0000);
    cycle(0, 0, 0, 0, 0, 0, 0, "post_rst_drain");

    // Streaming with no stall: one entry per cycle, pointers wrap twice.
    for (int k = 0; k < 10; k++) begin
      cycle(1, 32'(k + 1), 0, 32'h100 + 32'(4 * k), 2'(k), 0, 0, "stream");
      chk($sformatf("stream%0d.instr", k), 64'(o_instruction), 64'(k + 1));
      chk($sformatf("stream%0d.pc", k), 64'(o_pc_ff), 64'(32'h100 + 32'(4 * k)));
      chk($sformatf("stream%0d.pc8", k), 64'(o_pc_plus_8_ff), 64'(32'h108 + 32'(4 * k)));
    end
    cycle(0, 0, 0, 0, 0, 0, 0, "stream_drain");

    // Simultaneous push/pop at count 2.
    cycle(1, 32'h600, 0, 32'h600, 2'd0, 1, 0, "pp_fill");
    cycle(1, 32'h601, 0, 32'h604, 2'd1, 1, 0, "pp_fill");
    for (int j = 0; j < 5; j++) begin
      cycle(1, 32'h602 + 32'(j), 0, 32'h608, 2'(j + 2), 0, 0, "pushpop");
      chk($sformatf("pushpop%0d.count", j), 64'(o_count), 64'd2);
      chk($sformatf("pushpop%0d.taken", j), 64'(o_taken), 64'((j + 1) % 4));
    end
    cycle(0, 0, 0, 0, 0, 0, 1, "pp_clear");

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0, $urandom,
            2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zap_fetch_fifo.md
Name: zap_fetch_fifo

Overview:
- Small instruction buffer between the fetch stage and decode.
- Absorbs fetch output (instruction, abort flag, PC, PC+8, branch prediction) into a DEPTH-entry circular FIFO.
- Presents the head entry to decode with first-word-fall-through semantics, and back-pressures fetch via o_full.
- Decouples I-side delivery from decode stalls and preserves abort ordering.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_clear  in  1  flush all entries; combined pipeline clear from writeback/ALU/decode.
- i_stall  in  1  downstream (decode/issue/shifter/data) stall; head is not consumed.
- i_valid  in  1  fetch output valid; push request.
- i_instruction  in  32  instruction word.
- i_instr_abort  in  1  instruction abort tag.
- i_pc_ff  in  32  PC of instruction.
- i_pc_plus_8_ff  in  32  PC+8 (PC+4 in compressed mode), passed through unchanged.
- i_taken  in  2  2-bit predictor state.
- o_full  out  1  count == DEPTH; fetch must hold.
- o_valid  out  1  head entry valid (count != 0).
- o_instruction  out  32  head instruction.
- o_instr_abort  out  1  head abort tag.
- o_pc_ff  out  32  head PC.
- o_pc_plus_8_ff  out  32  head PC+8.
- o_taken  out  2  head predictor state.
- o_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage: DEPTH x 99-bit entries, {taken[2], pc_plus_8[32], pc[32], abort[1], instr[32]}. Storage is not reset.
- Control state:
  - wr_ptr, rd_ptr: $clog2(DEPTH) bits, wrap modulo DEPTH naturally.
  - count: 0..DEPTH.
  - abort_lock_ff: 1 bit.
- Reset (i_reset_n low, asynchronous): count=0, pointers=0, abort_lock_ff=0. Outputs go low immediately: o_valid=0, o_full=0, o_count=0, payload outputs 0. Deassertion is synchronised externally.
- Outputs:
  - o_valid = (count != 0).
  - o_full = (count == DEPTH).
  - Payload outputs = entry[rd_ptr] when o_valid, else forced to 0.
  - All outputs are derived from registers only; there is no combinational path from any input.
- Push accepted = i_valid & !o_full & !abort_lock_ff & !i_clear.
  - Writes entry[wr_ptr]; wr_ptr+1.
  - Push while full or locked is silently dropped; fetch must honour o_full.
- Pop = o_valid & !i_stall & !i_clear. rd_ptr+1.
- Count update:
  - Push only: +1. Pop only: -1.
  - Push and pop in the same cycle: unchanged. Legal only when not full, because push requires !o_full.
- Latency: a push into an empty FIFO appears on outputs the next cycle (1-cycle latency). Back-to-back push/pop sustains 1 entry/cycle.
- Abort lock:
  - An accepted push with i_instr_abort=1 sets abort_lock_ff.
  - While the lock is set, no further pushes are accepted. Entries already queued, including the abort entry, still drain normally.
  - The lock is cleared only by i_clear or reset.
- Clear:
  - i_clear has the highest synchronous priority.
  - Next cycle: count=0, wr_ptr=rd_ptr=0, abort_lock_ff=0, o_valid=0.
  - A push and a pop in the same cycle as i_clear are both discarded.
- Stall: with i_stall=1, the head is held stable. Pushes continue until o_full.
- Empty with i_stall=0: no pop, no pointer change, count never underflows.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no special handling. FIFO order is preserved across the wrap.
- Clear while full: o_full drops the next cycle.

Test Plan:
1. Reset mid-operation: fill 3 entries, pulse i_reset_n low asynchronously between edges -> o_valid=0, o_count=0, o_instruction=0 immediately; after release, first push of 0xE0000000 appears at head next cycle.
2. Order and wrap: hold i_stall=0, push 10 sequential instructions 0x1..0xA with pc_ff=0x100+4k -> decode sees 0x1..0xA in order with matching pc and pc+8, no gaps beyond the initial 1-cycle latency, pointers wrap twice.
3. Full/back-pressure: i_stall=1, push 6 entries -> o_full=1 after 4th push, entries 5-6 dropped, o_count=4; release stall -> exactly the first 4 entries drain, then o_valid=0.
4. Abort lock: push A(abort=0), B(abort=1), C(abort=0) -> C dropped, A then B emitted with o_instr_abort=0,1; after i_clear, pushing D is accepted and emitted.
5. Clear priority: count=3, assert i_clear together with i_valid=1 and i_stall=0 -> next cycle o_valid=0, o_count=0, pushed entry absent.
6. Simultaneous push/pop at count=2 for 5 cycles -> o_count stays 2, outputs advance one entry per cycle, i_taken values 0..3 reproduced on o_taken in order.
